// File: rtl/act_lut_pkg.sv
// Shared constants and index/saturation helpers for the activation LUT pipeline.
package act_lut_pkg;

    localparam logic MODE_LUT  = 1'b0;
    localparam logic MODE_RELU = 1'b1;

    // Floor shift, clamp to the signed table range, then offset so idx 0 is most negative.
    function automatic int sat_idx(input int value, input int shift, input int addr_w);
        int sh;
        int lo;
        int hi;
        sh = value >>> shift;
        lo = -(1 << (addr_w - 1));
        hi = (1 << (addr_w - 1)) - 1;
        if (sh < lo) begin
            sh = lo;
        end else if (sh > hi) begin
            sh = hi;
        end
        return sh + (1 << (addr_w - 1));
    endfunction

    function automatic int relu_sat(input int value, input int out_w);
        int max_v;
        max_v = (1 << out_w) - 1;
        if (value < 0) begin
            return 0;
        end else if (value > max_v) begin
            return max_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/act_lut_ram.sv
// Single-write, registered-read table RAM with read-before-write on address collision.
module act_lut_ram #(
    parameter int    ADDR_W    = 5,
    parameter int    DATA_W    = 8,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    // Contents are deliberately not reset; the read register holds while re is low.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/act_lut_pipe.sv
// Two-stage activation unit: S1 computes index/ReLU, S2 holds the table read or ReLU result.
module act_lut_pipe
    import act_lut_pkg::*;
#(
    parameter int    IN_W      = 8,
    parameter int    ADDR_W    = 5,
    parameter int    OUT_W     = 8,
    parameter int    SHIFT     = 3,
    parameter int    TAG_W     = 4,
    parameter string INIT_FILE = ""
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_data,
    input  logic                   in_mode,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [TAG_W-1:0]       out_tag,
    input  logic                   cfg_we,
    input  logic [ADDR_W-1:0]      cfg_addr,
    input  logic [OUT_W-1:0]       cfg_data
);

    logic              en1;
    logic              en2;
    logic [ADDR_W-1:0] idx_next;
    logic [OUT_W-1:0]  relu_next;

    logic              s1_valid;
    logic              s1_mode;
    logic [TAG_W-1:0]  s1_tag;
    logic [ADDR_W-1:0] s1_idx;
    logic [OUT_W-1:0]  s1_relu;

    logic              s2_mode;
    logic [OUT_W-1:0]  s2_relu;
    logic [OUT_W-1:0]  ram_rdata;
    logic              ram_re;

    assign en2      = !out_valid || out_ready;
    assign en1      = !s1_valid || en2;
    assign in_ready = en1;

    always_comb begin
        idx_next  = ADDR_W'(sat_idx(int'(in_data), SHIFT, ADDR_W));
        relu_next = OUT_W'(relu_sat(int'(in_data), OUT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_LUT;
            s1_tag   <= '0;
            s1_idx   <= '0;
            s1_relu  <= '0;
        end else if (en1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= in_mode;
                s1_tag  <= in_tag;
                s1_idx  <= idx_next;
                s1_relu <= relu_next;
            end
        end
    end

    // S2 resets into ReLU mode with a zero value so out_data reads 0 without resetting the RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            s2_mode   <= MODE_RELU;
            s2_relu   <= '0;
        end else if (en2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_tag <= s1_tag;
                s2_mode <= s1_mode;
                s2_relu <= s1_relu;
            end
        end
    end

    assign ram_re   = en2 && s1_valid && (s1_mode == MODE_LUT);
    assign out_data = (s2_mode == MODE_RELU) ? s2_relu : ram_rdata;

    act_lut_ram #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (OUT_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .re    (ram_re),
        .raddr (s1_idx),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_act_lut_pipe.sv
// Bench for act_lut_pipe: SHIFT=3 and SHIFT=0 instances driven in lockstep against a queue model.
module tb_act_lut_pipe;

    localparam int IN_W   = 8;
    localparam int ADDR_W = 5;
    localparam int OUT_W  = 8;
    localparam int TAG_W  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                   in_valid = 1'b0;
    logic signed [IN_W-1:0] in_data = '0;
    logic                   in_mode = 1'b0;
    logic [TAG_W-1:0]       in_tag = '0;
    logic                   out_ready = 1'b1;
    logic                   cfg_we = 1'b0;
    logic [ADDR_W-1:0]      cfg_addr = '0;
    logic [OUT_W-1:0]       cfg_data = '0;

    logic             in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [OUT_W-1:0] out_data_a, out_data_b;
    logic [TAG_W-1:0] out_tag_a, out_tag_b;

    act_lut_pipe u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_tag(out_tag_a), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    act_lut_pipe #(.SHIFT(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_tag(out_tag_b), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    typedef struct {
        int data;
        int tag;
        int acc;
    } item_t;

    item_t qa[$];
    item_t qb[$];
    int    mem_m [32];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;

    // Reference: floor division by 2**shift, clamp to [-16,15], offset by 16.
    function automatic int ref_act(input int d, input bit mode, input int shift);
        int div;
        int q;
        if (mode) return (d < 0) ? 0 : ((d > 255) ? 255 : d);
        div = 1 << shift;
        q = d / div;
        if (d < 0 && (d % div) != 0) q = q - 1;
        if (q < -16) q = -16;
        if (q > 15) q = 15;
        return mem_m[q + 16];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int d, input bit m, input int t);
        in_valid = v;
        in_data  = IN_W'(d);
        in_mode  = m;
        in_tag   = TAG_W'(t);
    endtask

    // One cycle: check outputs against the model, update the model, advance to the next negedge.
    task automatic tick(output bit accepted);
        bit exp_ready;
        bit exp_ov;
        item_t it;
        #1;
        exp_ready = !(qa.size() == 2 && !out_ready);
        exp_ov    = (qa.size() > 0) && (cyc >= qa[0].acc + 2);
        chk("in_ready_a", 32'(in_ready_a), 32'(exp_ready));
        chk("in_ready_b", 32'(in_ready_b), 32'(exp_ready));
        chk("out_valid_a", 32'(out_valid_a), 32'(exp_ov));
        chk("out_valid_b", 32'(out_valid_b), 32'(exp_ov));
        if (exp_ov) begin
            chk("out_data_a", 32'(out_data_a), qa[0].data);
            chk("out_tag_a", 32'(out_tag_a), qa[0].tag);
            chk("out_data_b", 32'(out_data_b), qb[0].data);
            chk("out_tag_b", 32'(out_tag_b), qb[0].tag);
            if (out_ready) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
        end
        accepted = in_valid && exp_ready;
        if (accepted) begin
            it.tag = int'(in_tag);
            it.acc = cyc;
            it.data = ref_act(int'(in_data), in_mode, 3);
            qa.push_back(it);
            it.data = ref_act(int'(in_data), in_mode, 0);
            qb.push_back(it);
        end
        if (cfg_we) mem_m[cfg_addr] = int'(cfg_data);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int lut_in  [4] = '{0, -1, -128, 127};
        int sat_in  [2] = '{100, -100};
        int relu_in [3] = '{-5, 0, 100};
        int relu_tg [3] = '{3, 7, 15};
        int k;
        int n;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid_a), 32'(0));
        chk("rst_out_data", 32'(out_data_a), 32'(0));
        chk("rst_out_tag", 32'(out_tag_a), 32'(0));
        chk("rst_in_ready", 32'(in_ready_a), 32'(1));
        chk("rst_out_data_b", 32'(out_data_b), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            cfg_we = 1'b1; cfg_addr = ADDR_W'(i); cfg_data = OUT_W'(8 * i);
            tick(acc);
        end
        cfg_we = 1'b0;

        // LUT indexing, back-to-back, then saturation values
        for (int i = 0; i < 4; i++) begin drive(1, lut_in[i], 0, i); tick(acc); end
        for (int i = 0; i < 2; i++) begin drive(1, sat_in[i], 0, 8 + i); tick(acc); end
        for (int i = 0; i < 3; i++) begin drive(1, relu_in[i], 1, relu_tg[i]); tick(acc); end
        drive(0, 0, 0, 0);
        repeat (4) tick(acc);
        chk("drain1_empty", 32'(qa.size()), 32'(0));

        // Backpressure: six items, out_ready low for three cycles mid-stream
        k = 0; n = 0;
        while (n < 6 && k < 40) begin
            drive(1, $urandom_range(0, 255), $urandom_range(0, 1), n);
            out_ready = !(k >= 2 && k < 5);
            tick(acc);
            if (acc) n++;
            k++;
        end
        chk("bp_all_accepted", 32'(n), 32'(6));
        drive(0, 0, 0, 0); out_ready = 1'b1;
        repeat (4) tick(acc);
        chk("drain2_empty", 32'(qa.size()), 32'(0));

        // Write to idx 16 on the same edge that S2 reads it: old data returned
        drive(1, 0, 0, 5); tick(acc);
        drive(0, 0, 0, 0);
        cfg_we = 1'b1; cfg_addr = ADDR_W'(16); cfg_data = 8'hAA;
        tick(acc);
        cfg_we = 1'b0;
        drive(1, 0, 0, 6); tick(acc);
        drive(0, 0, 0, 0);
        repeat (4) tick(acc);
        chk("drain3_empty", 32'(qa.size()), 32'(0));

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 1),
                  $urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
        end
        drive(0, 0, 0, 0); out_ready = 1'b1;
        repeat (4) tick(acc);
        chk("drain4_empty", 32'(qa.size()), 32'(0));

        // Reset with two items in flight
        out_ready = 1'b0;
        drive(1, 10, 0, 1); tick(acc);
        drive(1, 20, 1, 2); tick(acc);
        drive(0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid_a", 32'(out_valid_a), 32'(0));
        chk("midrst_in_ready_a", 32'(in_ready_a), 32'(1));
        chk("midrst_out_valid_b", 32'(out_valid_b), 32'(0));
        chk("midrst_in_ready_b", 32'(in_ready_b), 32'(1));
        qa.delete(); qb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) tick(acc);
        drive(1, 0, 0, 9); tick(acc);
        drive(1, -1, 0, 10); tick(acc);
        drive(0, 0, 0, 0);
        repeat (4) tick(acc);
        chk("drain5_empty", 32'(qa.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
